bht_counter_table: RTL and testbench

Bimodal branch history table of 2-bit saturating counters, sized by the core configuration's `BHTEntries` (32 for the cv32a65x configuration). It sits in the frontend between the instruction-fetch PC and the branch predictor decision logic:
- It answers one combinational direction lookup per cycle for the fetch PC.
- It accepts one resolved-branch update per cycle from the execute stage, through a one-deep registered update stage.

---
 rtl/bht_counter_table.sv | 130 +++++++++++++
 tb/tb_bht_counter_table.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bht_counter_table.sv
// Bimodal branch history table built from 2-bit saturating counters.
// A lookup of the fetch PC is answered combinationally. A resolved-branch
// update is captured into a one-deep pending stage and written into the
// table on the following edge. Lookups and back-to-back updates to the same
// entry are served from the pending stage, so no training is lost.
module bht_counter_table #(
    parameter int unsigned NR_ENTRIES = 32,
    parameter int unsigned VLEN       = 32,
    parameter bit          RVC        = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_bp_i,
    input  logic            debug_mode_i,
    input  logic [VLEN-1:0] vpc_i,
    input  logic            upd_valid_i,
    input  logic [VLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    output logic            bht_valid_o,
    output logic            bht_taken_o
);

    localparam int unsigned IDX_W = $clog2(NR_ENTRIES);

    // Entry index: halfword granularity with compressed instructions, word
    // granularity without. Bits above the index alias onto the same entry.
    function automatic logic [IDX_W-1:0] pc_index(input logic [VLEN-1:0] pc);
        if (RVC) return pc[IDX_W:1];
        else     return pc[IDX_W+1:2];
    endfunction

    // Table state
    logic [NR_ENTRIES-1:0] valid_q;
    logic [1:0]            cnt_q [NR_ENTRIES];

    // Pending update stage
    logic                  p_valid_q;
    logic [IDX_W-1:0]      p_idx_q;
    logic [1:0]            p_cnt_q;

    // Update-side combinational signals
    logic [IDX_W-1:0]      upd_idx;
    logic                  upd_accept;
    logic                  upd_chained;
    logic                  base_valid;
    logic [1:0]            base_cnt;
    logic [1:0]            upd_cnt;

    // Lookup-side combinational signals
    logic [IDX_W-1:0]      lk_idx;
    logic                  lk_fwd;

    // Only the index bits of the PCs matter; the rest is deliberately dropped.
    logic                  unused_pc_bits;
    assign unused_pc_bits = ^{vpc_i, upd_pc_i};

    assign upd_idx     = pc_index(upd_pc_i);
    assign upd_accept  = upd_valid_i && !debug_mode_i && !flush_bp_i;
    assign upd_chained = p_valid_q && (p_idx_q == upd_idx);
    assign base_valid  = upd_chained || valid_q[upd_idx];
    assign base_cnt    = upd_chained ? p_cnt_q : cnt_q[upd_idx];

    // New counter value: first training seeds weakly, otherwise saturate.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        upd_cnt = 2'b00;
        if (!base_valid) begin
            upd_cnt = upd_taken_i ? 2'b10 : 2'b01;
        end else if (upd_taken_i) begin
            upd_cnt = (base_cnt == 2'b11) ? 2'b11 : base_cnt + 2'd1;
        end else begin
            upd_cnt = (base_cnt == 2'b00) ? 2'b00 : base_cnt - 2'd1;
        end
    end

    // Pending stage: capture one accepted update per cycle; flush discards it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: sequential state is assigned with <= so every flop samples
            // the pre-edge values regardless of statement order.
            p_valid_q <= 1'b0;
            p_idx_q   <= '0;
            p_cnt_q   <= 2'b00;
        end else if (flush_bp_i) begin
            p_valid_q <= 1'b0;
            p_idx_q   <= '0;
            p_cnt_q   <= 2'b00;
        end else begin
            p_valid_q <= upd_accept;
            if (upd_accept) begin
                p_idx_q <= upd_idx;
                p_cnt_q <= upd_cnt;
            end
        end
    end

    // Table: clear on reset/flush, otherwise commit the pending update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: this array is flop storage, not a RAM macro; it must be
            // reset because a cleared valid bit is what untrains an entry.
            valid_q <= '0;
            for (int i = 0; i < NR_ENTRIES; i++) cnt_q[i] <= 2'b00;
        end else if (flush_bp_i) begin
            valid_q <= '0;
            for (int i = 0; i < NR_ENTRIES; i++) cnt_q[i] <= 2'b00;
        end else if (p_valid_q) begin
            valid_q[p_idx_q] <= 1'b1;
            cnt_q[p_idx_q]   <= p_cnt_q;
        end
    end

    assign lk_idx = pc_index(vpc_i);
    assign lk_fwd = p_valid_q && (p_idx_q == lk_idx);

    // Lookup: forward from the pending stage when it targets the same entry.
    always_comb begin
        bht_valid_o = 1'b0;
        bht_taken_o = 1'b0;
        if (lk_fwd) begin
            bht_valid_o = 1'b1;
            bht_taken_o = p_cnt_q[1];
        end else if (valid_q[lk_idx]) begin
            bht_valid_o = 1'b1;
            bht_taken_o = cnt_q[lk_idx][1];
        end
    end

endmodule

// File: tb/tb_bht_counter_table.sv
// Self-checking bench for bht_counter_table: directed scenarios plus random
// traffic, checked against an architectural counter model via a scoreboard.
module tb_bht_counter_table;

    localparam int NR = 32;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_bp_i;
    logic        debug_mode_i;
    logic [31:0] vpc_i;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic        bht_valid_o;
    logic        bht_taken_o;

    bht_counter_table #(.NR_ENTRIES(NR), .VLEN(32), .RVC(1'b1)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_bp_i   (flush_bp_i),
        .debug_mode_i (debug_mode_i),
        .vpc_i        (vpc_i),
        .upd_valid_i  (upd_valid_i),
        .upd_pc_i     (upd_pc_i),
        .upd_taken_i  (upd_taken_i),
        .bht_valid_o  (bht_valid_o),
        .bht_taken_o  (bht_taken_o)
    );

    // Clock generation
    always #5 clk_i = ~clk_i;

    typedef struct {
        string name;
        logic  v;
        logic  t;
    } exp_s;

    exp_s exp_q[$];
    int   checks_total  = 0;
    int   checks_passed = 0;

    // Architectural model: counter value 0..3 per entry, -1 when untrained.
    // Updates take effect at the capture edge; forwarding/chaining in the
    // design must make that indistinguishable from the outside.
    int model_cnt [NR];

    function automatic int midx(input logic [31:0] pc);
        return int'((pc >> 1) % NR);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NR; i++) model_cnt[i] = -1;
    endfunction

    function automatic void model_update(input logic [31:0] pc, input logic taken);
        int i;
        i = midx(pc);
        if (model_cnt[i] < 0)  model_cnt[i] = taken ? 2 : 1;
        else if (taken)        model_cnt[i] = (model_cnt[i] < 3) ? model_cnt[i] + 1 : 3;
        else                   model_cnt[i] = (model_cnt[i] > 0) ? model_cnt[i] - 1 : 0;
    endfunction

    task automatic push_lookup(input string name, input logic [31:0] pc);
        exp_s e;
        int   c;
        c = model_cnt[midx(pc)];
        e.name = name;
        e.v = (c >= 0);
        e.t = (c >= 2);
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic act_v, input logic act_t,
                         input logic exp_v, input logic exp_t);
        checks_total++;
        if (act_v === exp_v && act_t === exp_t) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got valid=%b taken=%b, expected valid=%b taken=%b",
                     name, act_v, act_t, exp_v, exp_t);
        end
    endtask

    // Monitor: compare the combinational outputs away from the active edge.
    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            exp_s e;
            e = exp_q.pop_front();
            check(e.name, bht_valid_o, bht_taken_o, e.v, e.t);
        end
    end

    // One cycle: drive inputs, predict the lookup, then advance the model.
    task automatic step(input string name, input logic uv, input logic [31:0] upc,
                        input logic ut, input logic dbg, input logic fl,
                        input logic [31:0] lpc);
        upd_valid_i  = uv;
        upd_pc_i     = upc;
        upd_taken_i  = ut;
        debug_mode_i = dbg;
        flush_bp_i   = fl;
        vpc_i        = lpc;
        push_lookup(name, lpc);
        @(posedge clk_i);
        if (fl)             model_clear();
        else if (uv && !dbg) model_update(upc, ut);
        #1;
    endtask

    task automatic idle(input string name, input logic [31:0] lpc);
        step(name, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, lpc);
    endtask

    localparam logic [31:0] PC_A = 32'h8000_0010;
    localparam logic [31:0] PC_X = 32'h8000_0020;

    // Stimulus
    initial begin
        logic [31:0] upc, lpc;
        int          waited;

        model_clear();
        rst_ni       = 1'b0;
        flush_bp_i   = 1'b0;
        debug_mode_i = 1'b0;
        upd_valid_i  = 1'b0;
        upd_pc_i     = '0;
        upd_taken_i  = 1'b0;
        vpc_i        = 32'h8000_0000;
        push_lookup("in_reset", 32'h8000_0000);
        @(negedge clk_i);
        #2 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Reset state
        idle("rst_lookup_0", 32'h8000_0000);
        idle("rst_lookup_3e", 32'h8000_003E);

        // Saturation up, then down
        for (int k = 0; k < 4; k++) step($sformatf("tk_up%0d", k), 1'b1, PC_A, 1'b1, 1'b0, 1'b0, PC_A);
        for (int k = 0; k < 3; k++) step($sformatf("tk_dn%0d", k), 1'b1, PC_A, 1'b0, 1'b0, 1'b0, PC_A);
        idle("tk_after", PC_A);
        idle("tk_after2", PC_A);

        // Aliasing: 0x..04 and 0x..44 share index 2; 0x..06 is index 3
        step("alias_upd", 1'b1, 32'h8000_0004, 1'b1, 1'b0, 1'b0, 32'h8000_0044);
        idle("alias_fwd", 32'h8000_0044);
        idle("alias_tbl", 32'h8000_0044);
        idle("alias_idx3", 32'h8000_0006);

        // Chaining through the pending stage
        step("chain_nt", 1'b1, PC_X, 1'b0, 1'b0, 1'b0, PC_X);
        step("chain_tk", 1'b1, PC_X, 1'b1, 1'b0, 1'b0, PC_X);
        idle("chain_res", PC_X);
        idle("chain_res2", PC_X);

        // Debug mode suppresses training
        step("dbg_upd", 1'b1, 32'h8000_0030, 1'b1, 1'b1, 1'b0, 32'h8000_0030);
        idle("dbg_after", 32'h8000_0030);

        // Flush with an update pending and another arriving
        step("fl_pend", 1'b1, 32'h8000_0008, 1'b1, 1'b0, 1'b0, 32'h8000_0008);
        step("fl_flush", 1'b1, 32'h8000_000A, 1'b1, 1'b0, 1'b1, 32'h8000_0008);
        idle("fl_a", 32'h8000_0008);
        idle("fl_b", 32'h8000_000A);
        idle("fl_old", PC_A);

        // Async reset while an update is pending
        step("ar_upd", 1'b1, 32'h8000_000C, 1'b1, 1'b0, 1'b0, 32'h8000_000C);
        idle("ar_pend", 32'h8000_000C);
        step("ar_upd2", 1'b1, 32'h8000_000C, 1'b1, 1'b0, 1'b0, 32'h8000_000C);
        rst_ni      = 1'b0;
        upd_valid_i = 1'b0;
        model_clear();
        push_lookup("ar_during", 32'h8000_000C);
        @(negedge clk_i);
        #1 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        idle("ar_after", 32'h8000_000C);
        idle("ar_after2", 32'h8000_000C);

        // Random traffic over a few entries with aliasing high bits
        for (int k = 0; k < 400; k++) begin
            upc = 32'h8000_0000 | (32'($urandom_range(0, 7)) << 1) | (32'($urandom_range(0, 3)) << 6);
            if ($urandom_range(0, 2) == 0) lpc = upc;
            else lpc = 32'h8000_0000 | (32'($urandom_range(0, 7)) << 1) | (32'($urandom_range(0, 3)) << 6);
            step($sformatf("rnd%0d", k), ($urandom_range(0, 3) != 0), upc, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0), lpc);
        end

        upd_valid_i = 1'b0;
        flush_bp_i  = 1'b0;
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk_i);
            waited++;
        end
        if (exp_q.size() > 0) begin
            checks_total++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
